decoder_grant_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 3-to-8 active-low select decoder among 8 requesters.

---
 rtl/decoder_grant_arbiter.sv | 148 ++++++++++++++
 tb/tb_decoder_grant_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_grant_arbiter.sv
// decoder_grant_arbiter
//   Round-robin arbiter sharing one 3-to-8 active-low select decoder among
//   eight requesters. Each grant is held for at most HOLD_MAX cycles and is
//   followed by one idle gap cycle so that decoder outputs break before make.
// Ports
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset
//   en       : arbiter enable; low blocks new grants and releases a live one
//   req[7:0] : level requests, active-high
//   sel[2:0] : granted index, drives decoder {C,B,A}
//   g_n      : decoder enable G, active-low, low only while a grant is live
//   grant_n  : active-low one-hot grant, requester i -> bit (7-i)
//   busy     : high while a grant is live
//   preempt  : one-cycle pulse when a grant ends purely on the hold limit
module decoder_grant_arbiter #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [7:0]           req,
    output logic [2:0]           sel,
    output logic                 g_n,
    output logic [7:0]           grant_n,
    output logic                 busy,
    output logic                 preempt
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state,   w_state_nx;
    logic [IDX_W-1:0]   r_ptr,     w_ptr_nx;
    logic [CNT_W-1:0]   r_hold_cnt, w_hold_cnt_nx;
    logic [IDX_W-1:0]   r_sel,     w_sel_nx;
    logic               r_g_n,     w_g_n_nx;
    logic [N_REQ-1:0]   r_grant_n, w_grant_n_nx;
    logic               r_busy,    w_busy_nx;
    logic               r_preempt, w_preempt_nx;

    logic               w_found;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_idx;
    logic               w_rel_req;
    logic               w_rel_en;
    logic               w_rel_hold;

    // Rotating priority search starting at r_ptr
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = r_ptr + IDX_W'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Release causes for the live grant
    assign w_rel_req  = ~req[r_sel];
    assign w_rel_en   = ~en;
    assign w_rel_hold = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_sel      <= '0;
            r_g_n      <= 1'b1;
            r_grant_n  <= '1;
            r_busy     <= 1'b0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_hold_cnt <= w_hold_cnt_nx;
            r_sel      <= w_sel_nx;
            r_g_n      <= w_g_n_nx;
            r_grant_n  <= w_grant_n_nx;
            r_busy     <= w_busy_nx;
            r_preempt  <= w_preempt_nx;
        end
    end

    // Next state and next outputs; grant outputs default to inactive
    always_comb begin
        w_state_nx    = r_state;
        w_ptr_nx      = r_ptr;
        w_hold_cnt_nx = r_hold_cnt;
        w_sel_nx      = r_sel;
        w_g_n_nx      = 1'b1;
        w_grant_n_nx  = '1;
        w_busy_nx     = 1'b0;
        w_preempt_nx  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (en && w_found) begin
                    w_state_nx    = ST_GRANT;
                    w_sel_nx      = w_winner;
                    w_g_n_nx      = 1'b0;
                    w_grant_n_nx  = ~(8'b1000_0000 >> w_winner);
                    w_busy_nx     = 1'b1;
                    w_hold_cnt_nx = '0;
                end
            end
            ST_GRANT: begin
                if (w_rel_req || w_rel_en || w_rel_hold) begin
                    w_state_nx    = ST_GAP;
                    w_ptr_nx      = r_sel + IDX_W'(1);
                    w_hold_cnt_nx = '0;
                    // Only a pure hold-limit release counts as a preempt
                    w_preempt_nx  = w_rel_hold && !w_rel_req && !w_rel_en;
                end else begin
                    w_g_n_nx      = 1'b0;
                    w_grant_n_nx  = r_grant_n;
                    w_busy_nx     = 1'b1;
                    w_hold_cnt_nx = r_hold_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign sel     = r_sel;
    assign g_n     = r_g_n;
    assign grant_n = r_grant_n;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Bench for decoder_grant_arbiter: two instances (HOLD_MAX 2 and 4) share one
// stimulus; a behavioural owner/ptr model checks both every cycle, and the
// directed scenarios add literal expectations.
module tb_decoder_grant_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] req;

    logic [2:0] sel2, sel4;
    logic       g_n2, g_n4;
    logic [7:0] grant_n2, grant_n4;
    logic       busy2, busy4;
    logic       pre2, pre4;

    always #5 clk = ~clk;

    decoder_grant_arbiter #(.HOLD_MAX(2), .CNT_W(8)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .en(en), .req(req),
        .sel(sel2), .g_n(g_n2), .grant_n(grant_n2), .busy(busy2), .preempt(pre2)
    );

    decoder_grant_arbiter #(.HOLD_MAX(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .req(req),
        .sel(sel4), .g_n(g_n4), .grant_n(grant_n4), .busy(busy4), .preempt(pre4)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the decoder, for how many cycles, and where the search resumes
    int hmax[2] = '{2, 4};
    int m_owner[2];
    int m_cnt[2];
    int m_ptr[2];
    int m_last[2];
    bit m_gap[2];
    bit m_pre[2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_pre[d] = 1'b0;
            if (!reset_n) begin
                m_owner[d] = -1; m_cnt[d] = 0; m_ptr[d] = 0; m_last[d] = 0; m_gap[d] = 1'b0;
            end else if (m_gap[d]) begin
                m_gap[d] = 1'b0;
            end else if (m_owner[d] >= 0) begin
                if (!req[m_owner[d]] || !en || (m_cnt[d] == hmax[d] - 1)) begin
                    m_pre[d]   = req[m_owner[d]] && en;
                    m_ptr[d]   = (m_owner[d] + 1) % 8;
                    m_owner[d] = -1;
                    m_gap[d]   = 1'b1;
                end else begin
                    m_cnt[d]++;
                end
            end else if (en && req != 8'h00) begin
                for (int k = 0; k < 8; k++)
                    if (m_owner[d] < 0 && req[(m_ptr[d] + k) % 8]) m_owner[d] = (m_ptr[d] + k) % 8;
                m_last[d] = m_owner[d];
                m_cnt[d]  = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] one;
                logic [7:0] e_gnt;
                logic [2:0] a_sel;
                logic       a_gn, a_busy, a_pre;
                logic [7:0] a_gnt;
                one   = (m_owner[d] >= 0) ? (8'h80 >> m_owner[d]) : 8'h00;
                e_gnt = ~one;
                a_sel  = (d == 0) ? sel2     : sel4;
                a_gn   = (d == 0) ? g_n2     : g_n4;
                a_gnt  = (d == 0) ? grant_n2 : grant_n4;
                a_busy = (d == 0) ? busy2    : busy4;
                a_pre  = (d == 0) ? pre2     : pre4;
                check($sformatf("model_sel[H%0d]", hmax[d]),     32'(a_sel),  32'(m_last[d] % 8));
                check($sformatf("model_g_n[H%0d]", hmax[d]),     32'(a_gn),   32'(m_owner[d] < 0));
                check($sformatf("model_grant_n[H%0d]", hmax[d]), 32'(a_gnt),  32'(e_gnt));
                check($sformatf("model_busy[H%0d]", hmax[d]),    32'(a_busy), 32'(m_owner[d] >= 0));
                check($sformatf("model_preempt[H%0d]", hmax[d]), 32'(a_pre),  32'(m_pre[d]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 8'h00;
        en      = 1'b1;
        step();
        reset_n = 1'b1;
    endtask

    logic [7:0] pat_req [12] = '{8'h01, 8'h81, 8'h3C, 8'h00, 8'hA5, 8'hA5, 8'h10, 8'hFF, 8'h42, 8'h42, 8'h08, 8'hC3};
    bit         pat_en  [12] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1};

    initial begin
        int q_sel[$];
        int n_pre;
        bit prev_gn;

        // 1: reset held with all requests active
        reset_n = 1'b0; en = 1'b1; req = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_on = 1'b1;
            check("rst_g_n",     32'(g_n4),     32'd1);
            check("rst_grant_n", 32'(grant_n4), 32'hFF);
            check("rst_sel",     32'(sel4),     32'd0);
            check("rst_busy",    32'(busy4),    32'd0);
        end

        // 2: single requester, then drop
        reset_n = 1'b1; req = 8'h04;
        step();
        check("single_sel",     32'(sel4),     32'd2);
        check("single_grant_n", 32'(grant_n4), 32'hDF);
        check("single_g_n",     32'(g_n4),     32'd0);
        req = 8'h00;
        step();
        check("drop_g_n",     32'(g_n4),  32'd1);
        check("drop_busy",    32'(busy4), 32'd0);
        check("drop_preempt", 32'(pre4),  32'd0);
        step();
        check("gap_g_n", 32'(g_n4), 32'd1);

        // 3: full round robin on the HOLD_MAX=2 instance
        do_reset();
        req = 8'hFF;
        n_pre = 0;
        prev_gn = 1'b1;
        for (int i = 0; i < 34; i++) begin
            step();
            if (!g_n2 && prev_gn) q_sel.push_back(int'(sel2));
            if (pre2) n_pre++;
            prev_gn = g_n2;
        end
        check("rr_grant_count", 32'(q_sel.size()), 32'd9);
        for (int k = 0; k < q_sel.size() && k < 9; k++)
            check($sformatf("rr_order[%0d]", k), 32'(q_sel[k]), 32'(k % 8));
        check("rr_preempt_count", 32'(n_pre), 32'd8);

        // 4: sole requester hits the hold limit on the HOLD_MAX=4 instance
        do_reset();
        req = 8'h80;
        step();
        check("sole_sel",     32'(sel4),     32'd7);
        check("sole_grant_n", 32'(grant_n4), 32'hFE);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sole_held", 32'(g_n4), 32'd0);
        end
        step();
        check("sole_release_g_n",   32'(g_n4), 32'd1);
        check("sole_preempt",       32'(pre4), 32'd1);
        step();
        check("sole_idle_g_n",      32'(g_n4), 32'd1);
        check("sole_preempt_pulse", 32'(pre4), 32'd0);
        step();
        check("sole_regrant_g_n",     32'(g_n4),     32'd0);
        check("sole_regrant_sel",     32'(sel4),     32'd7);
        check("sole_regrant_grant_n", 32'(grant_n4), 32'hFE);

        // 5: enable dropped mid-grant
        do_reset();
        req = 8'h08;
        step();
        check("en_sel", 32'(sel4), 32'd3);
        en = 1'b0;
        step();
        check("en_release_g_n", 32'(g_n4), 32'd1);
        check("en_no_preempt",  32'(pre4), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("en_blocked", 32'(g_n4), 32'd1);
        end
        en = 1'b1;

        // 6: reset during a grant clears the pointer
        do_reset();
        req = 8'h04;
        step();
        check("mid_sel", 32'(sel4), 32'd2);
        reset_n = 1'b0;
        step();
        check("mid_rst_sel",     32'(sel4),     32'd0);
        check("mid_rst_g_n",     32'(g_n4),     32'd1);
        check("mid_rst_grant_n", 32'(grant_n4), 32'hFF);
        check("mid_rst_busy",    32'(busy4),    32'd0);
        check("mid_rst_preempt", 32'(pre4),     32'd0);
        reset_n = 1'b1; req = 8'h81;
        step();
        check("mid_first_sel",     32'(sel4),     32'd0);
        check("mid_first_grant_n", 32'(grant_n4), 32'h7F);

        // Mixed request/enable patterns, checked by the model
        for (int p = 0; p < 12; p++) begin
            req = pat_req[p];
            en  = pat_en[p];
            for (int i = 0; i < 3; i++) step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
